slot_reel_ctrl: RTL



---
 rtl/slot_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 61 ++++++
 rtl/slot_reel_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the two-reel slot machine front end:
// spin FSM states, LFSR seed/taps and per-reel step sizes.
package slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SPIN_BOTH = 2'd1,
    ST_SPIN_ONE  = 2'd2,
    ST_RESULT    = 2'd3
  } state_e;

  localparam logic [7:0] LFSR_SEED  = 8'hA5;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [3:0] REEL0_STEP = 4'd1;
  localparam logic [3:0] REEL1_STEP = 4'd3;

  // Fibonacci step, taps 8,6,5,4: the seed is non-zero and the polynomial is
  // primitive, so the register walks all 255 non-zero values.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchroniser, stability-count debounce and a
// one-cycle pulse on each accepted 0->1 edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 240000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned    CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             press_q, press_d;

  // NOTE: every *_d gets its hold value first, so no path leaves a latch.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    level_prev_d = level_q;
    press_d      = level_q & ~level_prev_q;
  end

  // NOTE: state registers use non-blocking assignment only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/slot_reel_ctrl.sv
// Two-reel slot machine: a debounced button starts a spin from LFSR start
// positions; reels stop on presses or after STOP_GAP idle step ticks.
module slot_reel_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 240000,
  parameter int unsigned STEP_CYCLES = 2400000,
  parameter int unsigned STOP_GAP    = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic       spinning,
  output logic       win
);

  localparam int unsigned      STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam int unsigned      GAP_W     = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STOP_GAP - 1);

  logic press;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(btn_raw),
    .press  (press)
  );

  state_e            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [STEP_W-1:0] timer_q, timer_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [3:0]        digit0_q, digit0_d;
  logic [3:0]        digit1_q, digit1_d;
  logic              spinning_q, spinning_d;
  logic              win_q, win_d;
  logic              tick;
  logic              stop;

  always_comb begin
    lfsr_d   = lfsr_next(lfsr_q);
    tick     = (timer_q == STEP_LAST);
    timer_d  = tick ? '0 : timer_q + 1'b1;
    stop     = press || (tick && (gap_q == GAP_LAST));
    state_d  = state_q;
    digit0_d = digit0_q;
    digit1_d = digit1_q;
    gap_d    = gap_q;

    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (press) begin
          state_d  = ST_SPIN_BOTH;
          digit0_d = lfsr_q[3:0];
          digit1_d = lfsr_q[7:4];
          timer_d  = '0;
        end
      end
      ST_SPIN_BOTH: begin
        // A tick coinciding with the stop press still moves reel 0 once.
        if (tick) begin
          digit0_d = digit0_q + REEL0_STEP;
          digit1_d = digit1_q + REEL1_STEP;
        end
        if (stop)      state_d = ST_SPIN_ONE;
        else if (tick) gap_d   = gap_q + 1'b1;
      end
      ST_SPIN_ONE: begin
        if (tick) digit1_d = digit1_q + REEL1_STEP;
        if (stop)      state_d = ST_RESULT;
        else if (tick) gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Gap only matters while spinning; any state change restarts it.
    if (state_d != state_q) gap_d = '0;

    spinning_d = (state_d == ST_SPIN_BOTH) || (state_d == ST_SPIN_ONE);
    win_d      = (state_d == ST_RESULT) && (digit0_d == digit1_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      timer_q    <= '0;
      gap_q      <= '0;
      digit0_q   <= 4'd0;
      digit1_q   <= 4'd0;
      spinning_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      digit0_q   <= digit0_d;
      digit1_q   <= digit1_d;
      spinning_q <= spinning_d;
      win_q      <= win_d;
    end
  end

  assign digit0   = digit0_q;
  assign digit1   = digit1_q;
  assign spinning = spinning_q;
  assign win      = win_q;

endmodule
